// File: rtl/riscv_v_permutation_wb_stage.sv
// Writeback stage behind the vector permutation ALU: an in-order FIFO of ALU results that
// retires each head entry to either the scalar or the vector regfile write port.
module riscv_v_permutation_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int VDATA_W    = 128,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_is_v2i,
    input  logic                       in_is_i2v,
    input  logic [REG_ADDR_W-1:0]      in_rd_addr,
    input  logic [DATA_W-1:0]          in_int_data,
    input  logic [VDATA_W-1:0]         in_vec_data,
    input  logic [VDATA_W/8-1:0]       in_vec_be,
    output logic                       x_wb_valid,
    input  logic                       x_wb_ready,
    output logic [REG_ADDR_W-1:0]      x_wb_addr,
    output logic [DATA_W-1:0]          x_wb_data,
    output logic                       v_wb_valid,
    input  logic                       v_wb_ready,
    output logic [REG_ADDR_W-1:0]      v_wb_addr,
    output logic [VDATA_W-1:0]         v_wb_data,
    output logic [VDATA_W/8-1:0]       v_wb_be,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       busy,
    output logic                       err_both
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = VDATA_W / 8;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_both_q, err_both_d;

    logic                  mem_dest_x_q [DEPTH];
    logic [REG_ADDR_W-1:0] mem_addr_q   [DEPTH];
    logic [DATA_W-1:0]     mem_int_q    [DEPTH];
    logic [VDATA_W-1:0]    mem_vec_q    [DEPTH];
    logic [BE_W-1:0]       mem_be_q     [DEPTH];

    logic push, pop, have_head, head_dest_x;

    assign in_ready    = (count_q != CNT_W'(DEPTH)) && !flush;
    assign push        = in_valid && in_ready;
    assign have_head   = (count_q != '0);
    assign head_dest_x = mem_dest_x_q[rd_ptr_q];
    assign x_wb_valid  = have_head && head_dest_x;
    assign v_wb_valid  = have_head && !head_dest_x;
    // A flush cycle ignores any handshake on the writeback side.
    assign pop         = !flush && ((x_wb_valid && x_wb_ready) || (v_wb_valid && v_wb_ready));

    // Payloads are gated so the idle port always presents zeros.
    assign x_wb_addr = x_wb_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign x_wb_data = x_wb_valid ? mem_int_q[rd_ptr_q]  : '0;
    assign v_wb_addr = v_wb_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign v_wb_data = v_wb_valid ? mem_vec_q[rd_ptr_q]  : '0;
    assign v_wb_be   = v_wb_valid ? mem_be_q[rd_ptr_q]   : '0;

    assign occupancy = count_q;
    assign busy      = have_head;
    assign err_both  = err_both_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_both_d = err_both_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push && in_is_v2i && in_is_i2v) err_both_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_both_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_both_q <= err_both_d;
        end
    end

    // Storage is unreset; the count gates every read so stale contents never leak out.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_dest_x_q[gi] <= in_is_v2i;
                mem_addr_q[gi]   <= in_rd_addr;
                mem_int_q[gi]    <= in_int_data;
                mem_vec_q[gi]    <= in_vec_data;
                mem_be_q[gi]     <= in_vec_be;
            end
        end
    end
endmodule

// File: tb/tb_riscv_v_permutation_wb_stage.sv
// Bench for the permutation writeback stage: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based model of the in-order FIFO.
module tb_riscv_v_permutation_wb_stage;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0, in_is_v2i = 1'b0, in_is_i2v = 1'b0;
    logic [4:0]   in_rd_addr = '0;
    logic [31:0]  in_int_data = '0;
    logic [127:0] in_vec_data = '0;
    logic [15:0]  in_vec_be = '0;
    logic         x_wb_ready = 1'b0, v_wb_ready = 1'b0;
    logic         in_ready, x_wb_valid, v_wb_valid, busy, err_both;
    logic [4:0]   x_wb_addr, v_wb_addr;
    logic [31:0]  x_wb_data;
    logic [127:0] v_wb_data;
    logic [15:0]  v_wb_be;
    logic [2:0]   occupancy;

    riscv_v_permutation_wb_stage #(.DATA_W(32), .VDATA_W(128), .REG_ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_v2i(in_is_v2i), .in_is_i2v(in_is_i2v),
        .in_rd_addr(in_rd_addr), .in_int_data(in_int_data), .in_vec_data(in_vec_data),
        .in_vec_be(in_vec_be),
        .x_wb_valid(x_wb_valid), .x_wb_ready(x_wb_ready), .x_wb_addr(x_wb_addr), .x_wb_data(x_wb_data),
        .v_wb_valid(v_wb_valid), .v_wb_ready(v_wb_ready), .v_wb_addr(v_wb_addr), .v_wb_data(v_wb_data),
        .v_wb_be(v_wb_be), .occupancy(occupancy), .busy(busy), .err_both(err_both)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         dx;
        logic [4:0]   a;
        logic [31:0]  d;
        logic [127:0] v;
        logic [15:0]  be;
    } ent_t;

    ent_t q[$];
    logic model_err = 1'b0;
    int   checks = 0;
    int   passes = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        logic hx, hv;
        hx = (q.size() > 0) && q[0].dx;
        hv = (q.size() > 0) && !q[0].dx;
        check_eq("in_ready",  in_ready,  (q.size() < DEPTH) && !flush);
        check_eq("occupancy", occupancy, q.size());
        check_eq("busy",      busy,      q.size() != 0);
        check_eq("x_valid",   x_wb_valid, hx);
        check_eq("v_valid",   v_wb_valid, hv);
        check_eq("x_addr",    x_wb_addr, hx ? q[0].a : 5'd0);
        check_eq("x_data",    x_wb_data, hx ? q[0].d : 32'd0);
        check_eq("v_addr",    v_wb_addr, hv ? q[0].a : 5'd0);
        check_eq("v_data",    v_wb_data, hv ? q[0].v : 128'd0);
        check_eq("v_be",      v_wb_be,   hv ? q[0].be : 16'd0);
        check_eq("err_both",  err_both,  model_err);
    endtask

    // One clock: the model advances with the inputs present at the edge, then outputs are checked.
    task automatic cycle();
        logic can_push, do_pop;
        ent_t e;
        @(posedge clk);
        if (rst_n) begin
            can_push = in_valid && (q.size() < DEPTH) && !flush;
            do_pop   = !flush && (q.size() > 0) && (q[0].dx ? x_wb_ready : v_wb_ready);
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) begin
                    $display("retire %s rd=%0d", q[0].dx ? "x" : "v", q[0].a);
                    void'(q.pop_front());
                end
                if (can_push) begin
                    e.dx = in_is_v2i; e.a = in_rd_addr; e.d = in_int_data;
                    e.v = in_vec_data; e.be = in_vec_be;
                    q.push_back(e);
                    if (in_is_v2i && in_is_i2v) model_err = 1'b1;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic v2i, input logic i2v, input logic [4:0] rd);
        in_valid = v; in_is_v2i = v2i; in_is_i2v = i2v; in_rd_addr = rd;
        in_int_data = $urandom;
        in_vec_data = {$urandom, $urandom, $urandom, $urandom};
        in_vec_be   = 16'($urandom);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        q.delete();
        model_err = 1'b0;
        check_outputs();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Single scalar result retires the cycle after it is pushed.
        x_wb_ready = 1'b1;
        drive(1, 1, 0, 5'd5);
        in_int_data = 32'hDEADBEEF;
        cycle();
        check_eq("t1_xaddr", x_wb_addr, 5);
        check_eq("t1_xdata", x_wb_data, 32'hDEADBEEF);
        drive(0, 0, 0, 0);
        cycle();
        check_eq("t1_busy", busy, 0);

        // Fill with vector entries under back-pressure, then drain in order.
        v_wb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 1, 5'(i));
            cycle();
        end
        check_eq("t2_occ", occupancy, 4);
        check_eq("t2_rdy", in_ready, 0);
        drive(0, 0, 0, 0);
        v_wb_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("t2_order", v_wb_addr, i);
            cycle();
        end
        check_eq("t2_empty", busy, 0);

        // Stalled scalar head blocks the vector entries queued behind it.
        x_wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, (i % 2) == 0, (i % 2) != 0, 5'(10 + i));
            cycle();
        end
        drive(0, 0, 0, 0);
        cycle();
        check_eq("t3_blocked", occupancy, 4);
        x_wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Back-to-back streaming of 20 entries.
        for (int i = 0; i < 20; i++) begin
            drive(1, $urandom_range(0, 1), 0, 5'(i));
            cycle();
        end
        drive(0, 0, 0, 0);
        cycle();
        check_eq("t4_drained", occupancy, 0);

        // Flush with a push pending discards everything.
        x_wb_ready = 1'b0; v_wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 5'(20 + i));
            cycle();
        end
        drive(1, 0, 1, 5'd30);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(0, 0, 0, 0);
        check_eq("t5_occ", occupancy, 0);
        check_eq("t5_vval", v_wb_valid, 0);
        cycle();

        // Both routing flags: scalar port, sticky error survives flush, cleared by reset.
        drive(1, 1, 1, 5'd7);
        cycle();
        drive(0, 0, 0, 0);
        check_eq("t6_xval", x_wb_valid, 1);
        check_eq("t6_err", err_both, 1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check_eq("t6_err_flush", err_both, 1);
        do_reset();
        check_eq("t6_err_rst", err_both, 0);

        // Random traffic with occasional flushes and one reset mid-transfer.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                  5'($urandom));
            x_wb_ready = $urandom_range(0, 3) != 0;
            v_wb_ready = $urandom_range(0, 3) != 0;
            flush      = $urandom_range(0, 31) == 0;
            if (i == 200) do_reset();
            cycle();
        end
        flush = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
